// File: rtl/uart_pkg.sv
// Shared UART constants and the arbiter FSM state encoding, used by every
// UART block on the board.
package uart_pkg;

    localparam int unsigned CYCLE_1s     = 50_000_000;
    localparam int unsigned BAUDRATE     = 115_200;
    localparam int unsigned CYCLE_UART   = CYCLE_1s / BAUDRATE;
    localparam logic [7:0]  LOCK_CHAR    = 8'h0A;
    localparam int unsigned LOCK_TIMEOUT = 50_000;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serializer: start bit, eight data bits LSB first, stop bit,
// each bit CYCLE_UART clocks long.
module uart_byte_tx #(
    parameter int unsigned CYCLE_UART = uart_pkg::CYCLE_UART
) (
    input  logic       clk,
    input  logic       res_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int unsigned TW = $clog2(CYCLE_UART + 1);

    logic [TW-1:0] timer;
    logic [3:0]    bit_idx;
    logic [7:0]    shreg;
    logic          bit_end;

    assign bit_end = (timer == TW'(CYCLE_UART - 1));
    // bit_idx 0 is the start bit, 1..8 data, 9 the stop bit
    assign done    = busy && bit_end && (bit_idx == 4'd9);

    always_ff @(posedge clk) begin
        if (!res_n) begin
            tx      <= 1'b1;
            busy    <= 1'b0;
            timer   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else if (!busy) begin
            if (start) begin
                busy    <= 1'b1;
                tx      <= 1'b0;
                shreg   <= data;
                timer   <= '0;
                bit_idx <= '0;
            end
        end else if (bit_end) begin
            timer <= '0;
            if (bit_idx == 4'd9) begin
                busy <= 1'b0;
                tx   <= 1'b1;
            end else begin
                // ones shifted in from the top become the stop bit
                bit_idx <= bit_idx + 4'd1;
                tx      <= shreg[0];
                shreg   <= {1'b1, shreg[7:1]};
            end
        end else begin
            timer <= timer + TW'(1);
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with line locking that shares one UART TX pin between
// NREQ byte producers; a line owner keeps the pin until LOCK_CHAR or timeout.
module uart_tx_arbiter #(
    parameter int unsigned NREQ         = 2,
    parameter int unsigned CYCLE_UART   = uart_pkg::CYCLE_UART,
    parameter logic [7:0]  LOCK_CHAR    = uart_pkg::LOCK_CHAR,
    parameter int unsigned LOCK_TIMEOUT = uart_pkg::LOCK_TIMEOUT,
    localparam int unsigned IDW         = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                clk,
    input  logic                res_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]     req_ready,
    output logic                uart_tx,
    output logic                busy,
    output logic [IDW-1:0]      grant_id
);

    import uart_pkg::*;

    localparam int unsigned TW = $clog2(LOCK_TIMEOUT + 1);

    state_t         state;
    logic           lock;
    logic [IDW-1:0] owner;
    logic [IDW-1:0] last;
    logic [TW-1:0]  tcnt;

    logic [IDW-1:0]  cand;
    logic            cand_ok;
    logic [IDW-1:0]  hs_id;
    logic            hs;
    logic [7:0]      hs_data;
    logic [NREQ-1:0] vshift;
    int unsigned     idx;
    logic            tx_busy;
    logic            tx_done;

    // Rotating scan starting one past the last granted requester
    always_comb begin
        cand    = '0;
        cand_ok = 1'b0;
        idx     = 0;
        vshift  = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx    = (32'(last) + k) % NREQ;
            vshift = req_valid >> idx;
            if (!cand_ok && vshift[0]) begin
                cand_ok = 1'b1;
                cand    = IDW'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (res_n && state == IDLE) begin
            if (lock)
                req_ready[owner] = req_valid[owner];
            else if (cand_ok)
                req_ready[cand] = 1'b1;
        end
    end

    assign hs    = |(req_ready & req_valid);
    assign hs_id = lock ? owner : cand;

    always_comb begin
        hs_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (hs_id == IDW'(i))
                hs_data = req_data[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            state    <= IDLE;
            lock     <= 1'b0;
            owner    <= '0;
            last     <= IDW'(NREQ - 1);
            tcnt     <= '0;
            grant_id <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs) begin
                        state    <= SEND;
                        grant_id <= hs_id;
                        last     <= hs_id;
                        tcnt     <= '0;
                        if (hs_data == LOCK_CHAR) begin
                            lock <= 1'b0;
                        end else begin
                            lock  <= 1'b1;
                            owner <= hs_id;
                        end
                    end else if (lock && !req_valid[owner]) begin
                        // release lands on the edge where the count reaches LOCK_TIMEOUT
                        if (tcnt == TW'(LOCK_TIMEOUT - 1))
                            lock <= 1'b0;
                        tcnt <= tcnt + TW'(1);
                    end
                end
                SEND: begin
                    if (tx_done)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    uart_byte_tx #(
        .CYCLE_UART(CYCLE_UART)
    ) u_byte_tx (
        .clk   (clk),
        .res_n (res_n),
        .start (hs),
        .data  (hs_data),
        .tx    (uart_tx),
        .busy  (tx_busy),
        .done  (tx_done)
    );

    assign busy = tx_busy;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the board's single UART-TX pin (PMOD[1]) between several byte producers, such as the chargen stream and a status/echo source. Each requester has a valid/ready byte port. A round-robin arbiter with line locking picks the next byte, and an internal serializer emits it as 8N1 frames. Lines from different requesters never interleave unless the owner stalls past a timeout.

## Interface
Parameters:
- `NREQ`, default 2: number of requesters (2..8).
- `CYCLE_UART`, default 434: clocks per UART bit (50 MHz / 115200).
- `LOCK_CHAR`, default 8'h0A: byte that ends a line and releases the lock.
- `LOCK_TIMEOUT`, default 50_000: idle clocks after which a stalled owner loses its lock.

Ports:
- `clk`, in, 1: system clock, 50 MHz.
- `res_n`, in, 1: reset. Synchronous, active-low.
- `req_valid`, in, NREQ: requester i has a byte.
- `req_data`, in, 8*NREQ: byte of requester i at bits [8i+7:8i].
- `req_ready`, out, NREQ: one-hot or zero; a byte transfers when `req_valid[i] & req_ready[i]`.
- `uart_tx`, out, 1: serial line, idle high.
- `busy`, out, 1: a frame is in progress.
- `grant_id`, out, clog2(NREQ) (min 1): requester of the current or last frame.

## Operation
- **Reset values** (while `res_n`=0 at a clk edge):
  - `uart_tx`=1, `busy`=0, `grant_id`=0, `req_ready`=0.
  - Lock is cleared and the timeout counter is 0.
  - Round-robin pointer `last`=NREQ-1, so requester 0 has first priority.
- **States:** IDLE → SEND → IDLE.
- **IDLE, unlocked:**
  - The candidate is the first i with `req_valid[i]`, scanning from `last+1` modulo NREQ.
  - `req_ready[candidate]`=1 combinationally; all other ready bits are 0.
  - No valid requester means all ready bits are 0.
- **IDLE, locked:** only `req_ready[owner]` may be 1, and only when `req_valid[owner]`=1.
- **Handshake in IDLE:**
  - Latch the byte; set `grant_id` and `last` to i; go to SEND.
  - If the byte equals LOCK_CHAR, clear the lock. Otherwise set lock with owner=i.
  - Timeout counter resets to 0.
- **Timeout:**
  - While locked in IDLE with `req_valid[owner]`=0, the counter increments each cycle.
  - When the counter reaches LOCK_TIMEOUT, the lock clears that cycle and arbitration is unlocked from the next cycle.
  - The counter does not run in SEND.
- **SEND frame:**
  - Start bit low, then data bits 0..7 (LSB first), then stop bit high.
  - Each bit lasts exactly CYCLE_UART clocks.
  - `busy`=1 for the whole frame. `req_ready` is all-zero throughout SEND.
- **Frame end:** after the stop bit's last cycle, return to IDLE with `uart_tx`=1.
- **Reset mid-frame:** the frame is truncated and `uart_tx` is high after the reset edge. No partial byte is resumed.
- **Simultaneous events:**
  - If the owner sends LOCK_CHAR while other requesters are valid, the next grant goes round-robin from the owner. Other requesters therefore win over the owner.
  - Timeout expiring in the same cycle that the owner asserts valid: the handshake wins and the lock persists.

## Timing
- Handshake at cycle T.
- `uart_tx` falls at the T+1 edge.
- Start bit covers T+1..T+CYCLE_UART.
- Stop bit ends at T+10*CYCLE_UART.
- IDLE resumes at T+10*CYCLE_UART+1.
- Earliest next handshake is T+10*CYCLE_UART+1. Minimum one full idle bit is not required.
- `uart_tx`, `busy` and `grant_id` are registered. `req_ready` is combinational from registered state and `req_valid` only, with no path from `req_data`.
- Bit counter width: clog2(CYCLE_UART+1). Timeout counter width: clog2(LOCK_TIMEOUT+1). Neither wraps.

## Structure
- **Shared `uart_pkg` include:** CYCLE_1s, BAUDRATE, CYCLE_UART, LOCK_CHAR, and the IDLE/SEND state encoding. chargen and future UART blocks use the same constants.
- **Sub-module `uart_byte_tx`:**
  - Inputs: `start`, `data[7:0]`. Outputs: `tx`, `busy`, `done`.
  - Runs the bit timer and bit index.
- **Arbiter top:** holds round-robin, lock and timeout logic only.

## Test plan
All scenarios use CYCLE_UART=4, LOCK_TIMEOUT=16, NREQ=2.
- **Single byte:** req0 sends 8'h61.
  - `uart_tx` high until T+1, then 4 cycles each of 0 | 1,0,0,0,0,1,1,0 | 1.
  - `busy` is high for 40 cycles and `grant_id`=0.
- **Line locking:** req0 queues "A\n" and req1 queues "b\n", both valid from reset.
  - Decoded order is A, \n, b, \n.
  - `req_ready[1]` stays 0 until req0's 0x0A handshake.
- **No-lock round-robin:** both requesters continuously send 0x0A.
  - `grant_id` alternates 0,1,0,1.
  - Handshakes are spaced exactly 41 cycles apart.
- **Lock timeout:** req0 sends 'x' then drops valid while req1 is valid.
  - `req_ready[1]` rises exactly 16 IDLE cycles after req0's frame ends.
  - If req0 re-asserts valid at cycle 15 instead, req0 is granted.
- **Reset mid-frame:** `res_n` is pulled low during bit 3.
  - `uart_tx`=1, `busy`=0 and `req_ready`=0 on the next edge.
  - After release, req0 has priority and no lock is held.
- **Handshake/ready rules:** `req_data` changes while not ready and produce no output change. Ready is never asserted to an invalid requester, and never to two requesters at once.
